// File: rtl/cpu_bus_pkg.sv
// Shared definitions for CPU-bus peripherals: interrupt controller register
// offsets, its FSM state encoding and its default base address.
package cpu_bus_pkg;

  localparam logic [1:0] IRQ_PENDING = 2'd0;
  localparam logic [1:0] IRQ_MASK    = 2'd1;
  localparam logic [1:0] IRQ_CLEAR   = 2'd2;
  localparam logic [1:0] IRQ_STATUS  = 2'd3;

  localparam logic [15:0] DEFAULT_IRQ_BASE = 16'hFF00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-bit two-flop synchroniser followed by a rising-edge detector.
module irq_sync_edge
  import cpu_bus_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] s1_r, s2_r, s3_r;

  // synchroniser chain plus one history stage for edge detection
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_r <= '0;
      s2_r <= '0;
      s3_r <= '0;
    end else begin
      s1_r <= din;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/irq_controller.sv
// Prioritised interrupt controller with a memory-mapped PENDING/MASK/CLEAR/STATUS
// register block on the CPU data bus.
module irq_controller
  import cpu_bus_pkg::*;
#(
  parameter int          NSRC      = 8,
  parameter logic [15:0] BASE_ADDR = DEFAULT_IRQ_BASE
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [NSRC-1:0] src,
  input  logic [15:0]     address,
  input  logic [31:0]     data,
  input  logic            wren,
  input  logic            stall,
  output logic [31:0]     q,
  output logic            hit,
  output logic            IRQ,
  output logic [7:0]      IRQn
);

  // Bit 0 has the highest priority, so scan downwards and keep the last hit.
  function automatic logic [7:0] lowest_set(input logic [NSRC-1:0] v);
    logic [7:0] idx;
    idx = 8'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 8'(i);
    end
    return idx;
  endfunction

  logic [NSRC-1:0] rise_s, pending_r, mask_r, clr_s, act_s;
  logic            sel_s, wr_s, held_active_s;
  logic [1:0]      offset_s;
  logic [31:0]     rdata_s, q_r;
  logic            hit_r, irq_r, next_irq_s;
  logic [7:0]      irqn_r, next_irqn_s;
  irq_state_t      state_r, next_state_s;
  logic            unused_data_s;

  irq_sync_edge #(.WIDTH(NSRC)) u_sync_edge (
    .clk    (clk),
    .nreset (nreset),
    .din    (src),
    .rise   (rise_s)
  );

  assign sel_s         = (address[15:2] == BASE_ADDR[15:2]);
  assign offset_s      = address[1:0];
  assign wr_s          = sel_s & wren & ~stall;
  assign clr_s         = (wr_s && offset_s == IRQ_CLEAR) ? data[NSRC-1:0] : '0;
  assign act_s         = pending_r & mask_r;
  assign unused_data_s = ^data;

  // read mux over the pre-write register values
  always_comb begin
    rdata_s = 32'd0;
    case (offset_s)
      IRQ_PENDING: rdata_s = 32'(pending_r);
      IRQ_MASK:    rdata_s = 32'(mask_r);
      IRQ_CLEAR:   rdata_s = 32'd0;
      IRQ_STATUS:  rdata_s = {irq_r, 23'd0, irqn_r};
      default:     rdata_s = 32'd0;
    endcase
  end

  // register file and registered read port; a new edge beats a same-cycle clear
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pending_r <= '0;
      mask_r    <= '0;
      q_r       <= 32'd0;
      hit_r     <= 1'b0;
    end else begin
      pending_r <= (pending_r & ~clr_s) | rise_s;
      if (wr_s && offset_s == IRQ_MASK) begin
        mask_r <= data[NSRC-1:0];
      end
      q_r   <= sel_s ? rdata_s : 32'd0;
      hit_r <= sel_s;
    end
  end

  // is the vector currently presented to the CPU still pending and enabled?
  always_comb begin
    held_active_s = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      held_active_s = held_active_s | (act_s[i] & (irqn_r == 8'(i)));
    end
  end

  // next-state logic; IRQn is held through ASSERT and GAP
  always_comb begin
    next_state_s = state_r;
    next_irq_s   = irq_r;
    next_irqn_s  = irqn_r;
    case (state_r)
      IDLE: begin
        if (act_s != '0) begin
          next_state_s = ASSERT;
          next_irq_s   = 1'b1;
          next_irqn_s  = lowest_set(act_s);
        end else begin
          next_irq_s = 1'b0;
        end
      end
      ASSERT: begin
        if (!held_active_s) begin
          next_state_s = GAP;
          next_irq_s   = 1'b0;
        end else begin
          next_irq_s = 1'b1;
        end
      end
      GAP: begin
        next_state_s = IDLE;
        next_irq_s   = 1'b0;
      end
      default: begin
        next_state_s = IDLE;
        next_irq_s   = 1'b0;
      end
    endcase
  end

  // FSM state and registered IRQ outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r <= IDLE;
      irq_r   <= 1'b0;
      irqn_r  <= 8'd0;
    end else begin
      state_r <= next_state_s;
      irq_r   <= next_irq_s;
      irqn_r  <= next_irqn_s;
    end
  end

  assign q    = q_r;
  assign hit  = hit_r;
  assign IRQ  = irq_r;
  assign IRQn = irqn_r;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: cycle model compared every cycle plus
// directed scenarios with literal expectations.
module tb_irq_controller;

  localparam int          NSRC = 8;
  localparam logic [15:0] BASE = 16'hFF00;

  logic            clk = 1'b0;
  logic            nreset = 1'b1;
  logic [NSRC-1:0] src = '0;
  logic [15:0]     address = 16'd0;
  logic [31:0]     data = 32'd0;
  logic            wren = 1'b0;
  logic            stall = 1'b0;
  logic [31:0]     q;
  logic            hit, IRQ;
  logic [7:0]      IRQn;

  int checks = 0;
  int passed = 0;

  irq_controller #(.NSRC(NSRC), .BASE_ADDR(BASE)) dut (
    .clk(clk), .nreset(nreset), .src(src), .address(address), .data(data),
    .wren(wren), .stall(stall), .q(q), .hit(hit), .IRQ(IRQ), .IRQn(IRQn)
  );

  always #5 clk = ~clk;

  // Model: src history, register contents, read port and the IRQ line as seen by the CPU.
  typedef struct packed {
    logic [7:0]  h1, h2, h3, pend, mask;
    logic [31:0] q;
    logic        hit, irq, hold;
    logic [7:0]  irqn;
  } model_t;

  model_t m;

  function automatic model_t step(model_t c, logic [7:0] s, logic [15:0] a,
                                  logic [31:0] d, logic we, logic st);
    model_t     n;
    logic [7:0] act, rise, clr;
    logic       sel, wr;
    n    = c;
    act  = c.pend & c.mask;
    rise = c.h2 & ~c.h3;
    sel  = (a >> 2) == (BASE >> 2);
    wr   = sel && we && !st;
    n.hit = sel;
    n.q   = 32'd0;
    if (sel) begin
      case (a[1:0])
        2'd0:    n.q = {24'd0, c.pend};
        2'd1:    n.q = {24'd0, c.mask};
        2'd3:    n.q = {c.irq, 23'd0, c.irqn};
        default: n.q = 32'd0;
      endcase
    end
    clr = (wr && a[1:0] == 2'd2) ? d[7:0] : 8'd0;
    if (wr && a[1:0] == 2'd1) n.mask = d[7:0];
    n.pend = (c.pend & ~clr) | rise;
    n.h1 = s;
    n.h2 = c.h1;
    n.h3 = c.h2;
    if (c.irq) begin
      if (!act[c.irqn[2:0]]) begin
        n.irq  = 1'b0;
        n.hold = 1'b1;
      end
    end else if (c.hold) begin
      n.hold = 1'b0;
    end else if (act != 8'd0) begin
      n.irq = 1'b1;
      for (int i = 7; i >= 0; i--) if (act[i]) n.irqn = 8'(i);
    end
    return n;
  endfunction

  always @(posedge clk or negedge nreset) begin
    if (!nreset) m <= '0;
    else         m <= step(m, src, address, data, wren, stall);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (nreset) begin
      chk("model_q", q, m.q);
      chk("model_hit", {31'd0, hit}, {31'd0, m.hit});
      chk("model_irq", {31'd0, IRQ}, {31'd0, m.irq});
      chk("model_irqn", {24'd0, IRQn}, {24'd0, m.irqn});
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [31:0] d, input logic st);
    address = BASE + {14'd0, off};
    data    = d;
    wren    = 1'b1;
    stall   = st;
    @(negedge clk);
    address = 16'd0;
    data    = 32'd0;
    wren    = 1'b0;
    stall   = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [15:0] a,
                          input logic [31:0] exp, input logic exp_hit);
    address = a;
    wren    = 1'b0;
    @(negedge clk);
    chk(name, q, exp);
    chk({name, "_hit"}, {31'd0, hit}, {31'd0, exp_hit});
    address = 16'd0;
  endtask

  task automatic chk_irq(input string name, input logic exp_irq, input logic [7:0] exp_n);
    chk({name, "_irq"}, {31'd0, IRQ}, {31'd0, exp_irq});
    if (exp_irq) chk({name, "_irqn"}, {24'd0, IRQn}, {24'd0, exp_n});
  endtask

  initial begin
    #2 nreset = 1'b0;
    #1 chk("rst_outputs", {q[30:0], hit}, 32'd0);
    chk_irq("rst", 1'b0, 8'd0);
    tick(2);
    nreset = 1'b1;
    tick(1);

    bus_read("rd_pending0", BASE + 16'd0, 32'd0, 1'b1);
    bus_read("rd_mask0",    BASE + 16'd1, 32'd0, 1'b1);
    bus_read("rd_clear0",   BASE + 16'd2, 32'd0, 1'b1);
    bus_read("rd_status0",  BASE + 16'd3, 32'd0, 1'b1);
    bus_read("rd_nosel",    16'hFF04,     32'd0, 1'b0);
    chk_irq("idle", 1'b0, 8'd0);

    bus_write(2'd1, 32'h0000_00FF, 1'b0);
    bus_read("rd_mask_ff", BASE + 16'd1, 32'h0000_00FF, 1'b1);
    src[3] = 1'b1;
    tick(1);
    src[3] = 1'b0;
    tick(2);
    chk_irq("src3_cyc3", 1'b0, 8'd0);
    chk("model_pend_08", {24'd0, m.pend}, 32'h0000_0008);
    tick(1);
    chk_irq("src3_cyc4", 1'b1, 8'd3);
    bus_read("rd_pending_08", BASE + 16'd0, 32'h0000_0008, 1'b1);
    bus_read("rd_status_3",   BASE + 16'd3, 32'h8000_0003, 1'b1);
    bus_write(2'd2, 32'h0000_0008, 1'b0);
    tick(3);
    chk_irq("after_clr3", 1'b0, 8'd0);

    src[5] = 1'b1;
    tick(4);
    chk_irq("src5", 1'b1, 8'd5);
    src[2] = 1'b1;
    tick(5);
    chk_irq("src5_held", 1'b1, 8'd5);
    bus_write(2'd2, 32'h0000_0020, 1'b0);
    chk_irq("clr5_c0", 1'b1, 8'd5);
    tick(1);
    chk_irq("clr5_gap", 1'b0, 8'd0);
    tick(1);
    chk_irq("clr5_idle", 1'b0, 8'd0);
    tick(1);
    chk_irq("src2", 1'b1, 8'd2);
    src = '0;
    bus_write(2'd2, 32'h0000_0004, 1'b0);
    tick(4);
    chk_irq("after_clr2", 1'b0, 8'd0);

    bus_write(2'd1, 32'h0000_0000, 1'b0);
    src[0] = 1'b1;
    tick(1);
    src[0] = 1'b0;
    tick(4);
    bus_read("rd_pending_01", BASE + 16'd0, 32'h0000_0001, 1'b1);
    chk_irq("masked", 1'b0, 8'd0);
    bus_write(2'd1, 32'h0000_0001, 1'b0);
    chk_irq("unmask_c1", 1'b0, 8'd0);
    tick(1);
    chk_irq("unmask_c2", 1'b1, 8'd0);

    src[0] = 1'b1;
    tick(2);
    bus_write(2'd2, 32'h0000_0001, 1'b0);
    bus_read("rd_set_wins", BASE + 16'd0, 32'h0000_0001, 1'b1);
    chk_irq("set_wins", 1'b1, 8'd0);
    src[0] = 1'b0;
    bus_write(2'd2, 32'h0000_0001, 1'b1);
    bus_read("rd_stalled_clr", BASE + 16'd0, 32'h0000_0001, 1'b1);
    bus_write(2'd2, 32'h0000_0001, 1'b0);
    bus_read("rd_cleared", BASE + 16'd0, 32'h0000_0000, 1'b1);
    tick(3);

    bus_write(2'd1, 32'h0000_000C, 1'b0);
    src = 8'h0C;
    tick(5);
    bus_read("rd_pending_0c", BASE + 16'd0, 32'h0000_000C, 1'b1);
    chk_irq("pre_reset", 1'b1, 8'd2);
    address = BASE;
    #2 nreset = 1'b0;
    #1 chk("async_rst_q", q, 32'd0);
    chk("async_rst_hit", {31'd0, hit}, 32'd0);
    chk("async_rst_irq", {31'd0, IRQ}, 32'd0);
    chk("async_rst_irqn", {24'd0, IRQn}, 32'd0);
    address = 16'd0;
    tick(2);
    nreset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk_irq("post_reset", 1'b0, 8'd0);
    end
    bus_read("rd_mask_post", BASE + 16'd1, 32'd0, 1'b1);
    tick(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt source for the CPU's IRQ/IRQn inputs.
- Collects up to 32 external request lines, synchronises them, edge-detects them and latches them into a pending register.
- Drives a single prioritised request with its number toward the CPU.
- Also a memory-mapped responder on the CPU data bus, so software can mask interrupts, inspect them and acknowledge them with ordinary LOAD/STORE accesses.

Parameters:
- NSRC, 8: number of interrupt source lines (1..32).
- BASE_ADDR, 16'hFF00: word address of register 0; must be 4-word aligned.

Ports:
- clk  input  1  system clock, rising edge.
- nreset  input  1  asynchronous, active-low reset.
- src  input  NSRC  raw interrupt request lines, asynchronous to clk, rising-edge significant.
- address  input  16  CPU bus word address.
- data  input  32  CPU bus write data.
- wren  input  1  CPU bus write enable.
- stall  input  1  CPU hold; bus writes are ignored while high.
- q  output  32  read data, registered.
- hit  output  1  high when q carries this block's read data (for the external read mux).
- IRQ  output  1  interrupt request to CPU.
- IRQn  output  8  interrupt number accompanying IRQ.

Behaviour:
- Reset: asynchronous, active-low. All flops clear while nreset=0.
  - q=0, hit=0, IRQ=0, IRQn=0.
  - pending=0, mask=0, sync/edge flops=0, FSM=IDLE.
- Input conditioning:
  - Per source: 2-flop synchroniser, then a third flop for edge detect.
  - edge[i] = s2[i] & ~s3[i]. A held-high line sets pending once only.
  - Latency from src rise to pending set: 3 clk.
- Decode:
  - sel = (address[15:2] == BASE_ADDR[15:2]).
  - offset = address[1:0].
- Register map, as word offsets:
  - 0 PENDING: read-only. Bits [NSRC-1:0] = pending, upper bits read 0.
  - 1 MASK: read/write. 1 = enabled. Only bits [NSRC-1:0] are stored.
  - 2 CLEAR: write-1-to-clear pending. Reads return 0.
  - 3 STATUS: read-only. Bit31 = IRQ, bits[7:0] = IRQn, all others 0.
- Writes: occur when sel & wren & ~stall. Writes to offsets 0 and 3 are ignored.
- Reads:
  - Every cycle: q <= sel ? reg[offset] : 0 and hit <= sel.
  - This gives 1-cycle read latency, matching the CPU's two-level load.
  - A read issued in the same cycle as a write returns the pre-write value.
- Pending update: pending <= (pending & ~clr) | edge.
  - clr is data[NSRC-1:0] on a valid CLEAR write, else 0.
  - If set and clear hit the same bit in the same cycle, set wins.
- Active vector: act = pending & mask. cand = index of the lowest set bit of act (bit 0 has highest priority).
- FSM (registered outputs):
  - IDLE: IRQ=0. If act≠0 → ASSERT, with IRQ<=1 and IRQn<=cand (zero-extended to 8 bits).
  - ASSERT: IRQ=1 and IRQn held stable, even if a higher-priority source arrives.
    - Leave when act[IRQn]=0, i.e. the bit is cleared or masked → GAP, with IRQ<=0. IRQn keeps its value.
  - GAP: one cycle with IRQ=0, then → IDLE. This guarantees the CPU sees a falling edge between two vectors.
  - Minimum IRQ low time between requests: 2 cycles (GAP + IDLE evaluation).
- Masked pending bits stay pending. Unmasking them later raises IRQ.
- NSRC<32: the unused src/pending/mask bits do not exist; reads return 0 there.
- Reset asserted mid-operation: immediate return to reset values. Pending interrupts are lost.

Decomposition:
- Shared package `cpu_bus_pkg`:
  - register offset constants: IRQ_PENDING=0, IRQ_MASK=1, IRQ_CLEAR=2, IRQ_STATUS=3.
  - FSM state encoding: IDLE, ASSERT, GAP.
  - default BASE_ADDR.
- One sub-module: `irq_sync_edge` (per-bit 2-flop synchroniser plus rising-edge detector, width NSRC).
- Priority encoder stays inline as a function.

Test Plan:
- Reset, then read all four offsets → q=0 on each, hit=1 one cycle after the address, IRQ=0.
- Write MASK=32'h0000_00FF, pulse src[3] high for 1 cycle → PENDING=8'h08, IRQ=1 with IRQn=3 four cycles after the rise; STATUS reads 32'h8000_0003.
- With src[5] then src[2] raised while IRQn=5 is asserted → IRQn stays 5; write CLEAR=8'h20 → IRQ low for 2 cycles (GAP, IDLE), then IRQ=1 with IRQn=2.
- MASK=0, pulse src[0] → PENDING=8'h01 and IRQ stays 0; write MASK=1 → IRQ=1 with IRQn=0 two cycles later.
- CLEAR write of 8'h01 in the same cycle as a new edge on src[0] → pending[0] stays 1; a CLEAR write with stall=1 → no change.
- Assert nreset low while IRQ=1 with pending=8'h0C → all outputs 0 immediately (asynchronously); after release, IRQ stays 0 with src held high and no new edges.
